// File: rtl/cache_access_scheduler.sv
// -----------------------------------------------------------------------------
// cache_access_scheduler
//
// Round-robin arbiter and miss sequencer in front of a set-associative cache.
// One access is in flight at a time. A miss optionally writes back a dirty
// victim, then fills the line through a request/acknowledge memory handshake.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/rw/addr   : per-requester access requests (addr packed)
//   req_ready           : one-hot accept strobe, only ever high in IDLE
//   resp_valid/resp_hit : one-hot completion pulse and its hit outcome
//   cache_lookup/rw/addr: one-cycle lookup strobe plus the held access
//   cache_hit/victim_dirty : lookup outcome, sampled in EVAL
//   mem_req/mem_we/mem_ack : memory handshake (we=1 writeback, we=0 fill)
//   busy, grant_id      : scheduler occupancy and current owner
//   hit/miss/wb_count   : saturating 32-bit statistics
// -----------------------------------------------------------------------------
module cache_access_scheduler #(
    parameter  int ADDRESS_SIZE = 16,
    parameter  int NUM_REQ      = 2,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic                            resp_hit,
    output logic                            cache_lookup,
    output logic                            cache_rw,
    output logic [ADDRESS_SIZE-1:0]         cache_address,
    input  logic                            cache_hit,
    input  logic                            cache_victim_dirty,
    output logic                            mem_req,
    output logic                            mem_we,
    input  logic                            mem_ack,
    output logic                            busy,
    output logic [IDW-1:0]                  grant_id,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count,
    output logic [31:0]                     wb_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVAL   = 3'd2,
        S_WB     = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [IDW:0]   NUM_REQ_EXT = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_REQ - 1);
    localparam logic [31:0]    CNT_MAX     = 32'hFFFF_FFFF;

    state_t                  r_state;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_grant;
    // First FILL cycle after a writeback keeps mem_req low so the memory
    // sees a clean break between the two transactions.
    logic                    r_fill_gap;
    logic [NUM_REQ-1:0]      r_resp_valid;
    logic                    r_resp_hit;
    logic                    r_cache_lookup;
    logic                    r_cache_rw;
    logic [ADDRESS_SIZE-1:0] r_cache_address;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic                    r_busy;
    logic [31:0]             r_hit_count;
    logic [31:0]             r_miss_count;
    logic [31:0]             r_wb_count;

    logic                    w_found;
    logic [IDW-1:0]          w_sel;
    logic [IDW:0]            w_cand;
    logic [NUM_REQ-1:0]      w_sel_onehot;
    logic [NUM_REQ-1:0]      w_grant_onehot;
    logic [ADDRESS_SIZE-1:0] w_addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign w_addr_arr[g] = req_addr[g*ADDRESS_SIZE +: ADDRESS_SIZE];
    end

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = {IDW{1'b0}};
        w_cand  = {(IDW + 1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW + 1)'(k);
            if (w_cand >= NUM_REQ_EXT) begin
                w_cand = w_cand - NUM_REQ_EXT;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDW-1:0];
            end else begin
                w_sel   = w_sel;
            end
        end
    end

    // One-hot decodes of the selected and the granted requester.
    always_comb begin
        w_sel_onehot   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_sel;
        w_grant_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << r_grant;
    end

    // Accept strobe: combinational in IDLE only, forced low while in reset.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (!reset && (r_state == S_IDLE) && w_found) begin
            req_ready = w_sel_onehot;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Scheduler FSM with registered outputs and saturating statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= {IDW{1'b0}};
            r_grant         <= {IDW{1'b0}};
            r_fill_gap      <= 1'b0;
            r_resp_valid    <= {NUM_REQ{1'b0}};
            r_resp_hit      <= 1'b0;
            r_cache_lookup  <= 1'b0;
            r_cache_rw      <= 1'b0;
            r_cache_address <= {ADDRESS_SIZE{1'b0}};
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_busy          <= 1'b0;
            r_hit_count     <= 32'd0;
            r_miss_count    <= 32'd0;
            r_wb_count      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cache_rw      <= req_rw[w_sel];
                        r_cache_address <= w_addr_arr[w_sel];
                        r_grant         <= w_sel;
                        r_cache_lookup  <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= S_LOOKUP;
                    end else begin
                        r_state         <= S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    r_cache_lookup <= 1'b0;
                    r_state        <= S_EVAL;
                end
                S_EVAL: begin
                    if (cache_hit) begin
                        if (r_hit_count != CNT_MAX) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end else begin
                            r_hit_count <= r_hit_count;
                        end
                        r_resp_valid <= w_grant_onehot;
                        r_resp_hit   <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        if (r_miss_count != CNT_MAX) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end else begin
                            r_miss_count <= r_miss_count;
                        end
                        r_mem_req  <= 1'b1;
                        r_fill_gap <= 1'b0;
                        if (cache_victim_dirty) begin
                            r_mem_we <= 1'b1;
                            r_state  <= S_WB;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (r_wb_count != CNT_MAX) begin
                            r_wb_count <= r_wb_count + 32'd1;
                        end else begin
                            r_wb_count <= r_wb_count;
                        end
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_fill_gap <= 1'b1;
                        r_state    <= S_FILL;
                    end else begin
                        r_state    <= S_WB;
                    end
                end
                S_FILL: begin
                    if (r_fill_gap) begin
                        // Idle cycle between phases; any ack here is not ours.
                        r_fill_gap <= 1'b0;
                        r_mem_req  <= 1'b1;
                    end else if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= w_grant_onehot;
                        r_resp_hit   <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_state      <= S_FILL;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= {NUM_REQ{1'b0}};
                    r_resp_hit   <= 1'b0;
                    r_busy       <= 1'b0;
                    if (r_grant == LAST_ID) begin
                        r_ptr <= {IDW{1'b0}};
                    end else begin
                        r_ptr <= r_grant + IDW'(1'b1);
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_fill_gap     <= 1'b0;
                    r_resp_valid   <= {NUM_REQ{1'b0}};
                    r_resp_hit     <= 1'b0;
                    r_cache_lookup <= 1'b0;
                    r_mem_req      <= 1'b0;
                    r_mem_we       <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_hit      = r_resp_hit;
    assign cache_lookup  = r_cache_lookup;
    assign cache_rw      = r_cache_rw;
    assign cache_address = r_cache_address;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign busy          = r_busy;
    assign grant_id      = r_grant;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;
    assign wb_count      = r_wb_count;

endmodule

// File: doc/cache_access_scheduler.md
Name: cache_access_scheduler

Overview:
- Round-robin arbiter and miss sequencer placed in front of the set-associative cache model.
- Accepts read/write accesses from NUM_REQ independent requesters and issues exactly one access at a time to the cache.
- Sequences the miss path through a memory handshake: optional dirty-victim writeback, then line fill.
- Returns a per-requester completion pulse and keeps hit, miss and writeback statistics.

Parameters:
- ADDRESS_SIZE, 16, width of every access address.
- NUM_REQ, 2, number of requesters (2..8).
- IDW, max(1,$clog2(NUM_REQ)), width of grant_id (derived, not overridable).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has an access pending.
- req_rw  in  NUM_REQ  0 = read, 1 = write; per requester.
- req_addr  in  NUM_REQ*ADDRESS_SIZE  packed addresses; requester i uses slice [i*ADDRESS_SIZE +: ADDRESS_SIZE].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_hit  out  1  outcome of the completing access; qualified by |resp_valid.
- cache_lookup  out  1  one-cycle strobe telling the cache to perform the access.
- cache_rw  out  1  registered rw of the current access.
- cache_address  out  ADDRESS_SIZE  registered address of the current access.
- cache_hit  in  1  lookup result; sampled in EVAL only.
- cache_victim_dirty  in  1  LRU victim is valid and dirty; sampled in EVAL only.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = writeback, 0 = fill.
- mem_ack  in  1  memory completion.
- busy  out  1  state != IDLE.
- grant_id  out  IDW  requester owning the current access.
- hit_count, miss_count, wb_count  out  32 each  saturating statistics counters.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; counters 0. Reset asserted mid-transaction abandons it immediately. No resp_valid is ever issued for the abandoned access. mem_req drops in the same cycle reset asserts.
- States: IDLE, LOOKUP, EVAL, WB, FILL, RESP.
- IDLE:
  - req_ready is combinational here only. It selects the first requester with req_valid set, searching from pointer upward with wrap.
  - At the clock edge, that requester's rw and addr latch into cache_rw and cache_address, grant_id latches, and the state moves to LOOKUP.
  - If no req_valid bit is set, stay in IDLE with req_ready = 0.
- LOOKUP: cache_lookup = 1 for exactly one cycle, then move to EVAL.
- EVAL: sample cache_hit and cache_victim_dirty.
  - Hit: go to RESP; hit_count += 1.
  - Miss with dirty victim: go to WB; miss_count += 1.
  - Miss with clean or invalid victim: go to FILL; miss_count += 1.
- WB: mem_req = 1, mem_we = 1, held until mem_ack is sampled high. Then wb_count += 1 and go to FILL.
- FILL: mem_req = 1, mem_we = 0, held until mem_ack. Then go to RESP.
  - mem_req deasserts for at least one cycle between WB and FILL.
  - mem_ack high in the first cycle of WB/FILL completes that phase in one cycle.
- RESP:
  - resp_valid[grant_id] = 1 for one cycle; resp_hit = 1 if EVAL saw a hit.
  - Pointer becomes (grant_id+1) mod NUM_REQ; return to IDLE.
  - No accept happens in this cycle. The earliest next req_ready is the following cycle.
- Latency, counting the accept edge as cycle 0:
  - Hit: resp_valid in cycle 3.
  - Clean miss: resp_valid in cycle 3 + number of FILL cycles.
  - Dirty miss: resp_valid in cycle 4 + WB cycles + FILL cycles, including the one idle cycle between phases.
- Stability: cache_rw, cache_address and grant_id are held constant from LOOKUP through RESP. Requester inputs are ignored outside IDLE.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 other transactions.
- mem_ack outside WB/FILL is ignored. A requester dropping req_valid while not granted is legal.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.

Test Plan:
- Reset, then requester 0 reads 16'h1230 with cache_hit = 1 in EVAL → req_ready = 2'b01 at cycle 0, cache_lookup at cycle 1, resp_valid = 2'b01 with resp_hit = 1 at cycle 3, hit_count = 1, mem_req never asserted.
- Both requesters valid continuously, all hits → grants alternate 0,1,0,1. Responses occur every 4 cycles; after 8 accesses hit_count = 8 and each requester has 4 resp_valid pulses.
- Write miss with cache_victim_dirty = 1, mem_ack delayed 3 cycles in WB and 2 in FILL → mem_we = 1 for 3 cycles, 1 idle cycle, mem_we = 0 for 2 cycles, resp_hit = 0, miss_count = 1, wb_count = 1.
- Clean read miss with mem_ack tied high → single-cycle FILL, resp_valid at cycle 4, wb_count = 0.
- Assert reset during FILL with mem_req high → mem_req = 0 in the same cycle, state IDLE, counters 0, no resp_valid for the abandoned access, next accept goes to requester 0.
- Preload hit_count to 32'hFFFF_FFFF via force, then one more hit → hit_count stays 32'hFFFF_FFFF.
